// File: rtl/chicken_pkg.sv
// -----------------------------------------------------------------------------
// chicken_pkg
// Shared definitions for the chicken-race game-control blocks
// (turn_sequencer, card_table, check_win).
//   - animal codes 0..5 printed on the cards and track tiles
//   - turn_sequencer FSM state encoding
//   - default player / card counts shared with check_win
//   - LFSR step used by the optional card shuffle (CARD_SHUFFLE_EN)
// -----------------------------------------------------------------------------
package chicken_pkg;

  localparam int NUM_PLAYERS_DEF = 4;
  localparam int NUM_CARDS_DEF   = 12;
  localparam int ANIMAL_W_DEF    = 3;
  localparam int NUM_ANIMALS     = 6;

  localparam logic [2:0] ANIMAL_HEN   = 3'd0;
  localparam logic [2:0] ANIMAL_FOX   = 3'd1;
  localparam logic [2:0] ANIMAL_EGG   = 3'd2;
  localparam logic [2:0] ANIMAL_WORM  = 3'd3;
  localparam logic [2:0] ANIMAL_SNAIL = 3'd4;
  localparam logic [2:0] ANIMAL_PIG   = 3'd5;

  // Step count saturates here; N is a 5-bit output.
  localparam logic [4:0] N_MAX = 5'd31;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PICK,
    ST_REVEAL,
    ST_JUDGE,
    ST_ADVANCE,
    ST_WAIT_WIN,
    ST_NEXT_TURN,
    ST_GAME_OVER
  } state_e;

  // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// -----------------------------------------------------------------------------
// turn_sequencer_if
// Player-input / game-output bundle of turn_sequencer.
//   start, pick_valid, pick_idx[3:0]   player controls
//   tile_animal[ANIMAL_W-1:0]          tile ahead of the current chicken
//   W                                  win flag from check_win
//   T[1:0], N[4:0], B                  turn / step / advance triple to check_win
//   reveal_en, reveal_idx[3:0]         card display control
//   game_over                          held after a win
// Modports: master drives the controls and observes the outputs (board side);
//           slave is the sequencer itself.
// -----------------------------------------------------------------------------
interface turn_sequencer_if #(
  parameter int ANIMAL_W = chicken_pkg::ANIMAL_W_DEF
);
  logic                start;
  logic                pick_valid;
  logic [3:0]          pick_idx;
  logic [ANIMAL_W-1:0] tile_animal;
  logic                W;
  logic [1:0]          T;
  logic [4:0]          N;
  logic                B;
  logic                reveal_en;
  logic [3:0]          reveal_idx;
  logic                game_over;

  modport master (
    output start, pick_valid, pick_idx, tile_animal, W,
    input  T, N, B, reveal_en, reveal_idx, game_over
  );

  modport slave (
    input  start, pick_valid, pick_idx, tile_animal, W,
    output T, N, B, reveal_en, reveal_idx, game_over
  );
endinterface

// File: rtl/card_table.sv
// -----------------------------------------------------------------------------
// card_table
// Combinational card layout: card index -> animal printed on its face.
// Card i carries animal (i mod 6), so each animal appears twice on 12 cards.
//   card_idx[3:0]            physical (or shuffled) card index
//   animal[ANIMAL_W-1:0]     animal code from chicken_pkg
// -----------------------------------------------------------------------------
module card_table
  import chicken_pkg::*;
#(
  parameter int ANIMAL_W = ANIMAL_W_DEF
) (
  input  logic [3:0]          card_idx,
  output logic [ANIMAL_W-1:0] animal
);

  logic [2:0] code;

  // NOTE: a default assignment ahead of the case keeps this purely
  // combinational; any path leaving code unassigned would infer a latch.
  always_comb begin
    code = ANIMAL_HEN;
    case (card_idx)
      4'd0,  4'd6,  4'd12: code = ANIMAL_HEN;
      4'd1,  4'd7,  4'd13: code = ANIMAL_FOX;
      4'd2,  4'd8,  4'd14: code = ANIMAL_EGG;
      4'd3,  4'd9,  4'd15: code = ANIMAL_WORM;
      4'd4,  4'd10:        code = ANIMAL_SNAIL;
      4'd5,  4'd11:        code = ANIMAL_PIG;
      default:             code = ANIMAL_HEN;
    endcase
  end

  assign animal = ANIMAL_W'(code);

endmodule

// File: rtl/turn_sequencer.sv
// -----------------------------------------------------------------------------
// turn_sequencer
// Runs player turns of the chicken-race game: accepts a face-down card pick,
// shows it for REVEAL_CYCLES clocks, compares its animal against the tile in
// front of the current chicken, and either emits an advance (T, N, B) to
// check_win or passes the turn on. A win reported on W ends the game.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   bus        turn_sequencer_if.slave (controls in, game outputs out)
//
// Build option:
//   CARD_SHUFFLE_EN  defined: a free-running 16-bit LFSR picks a per-game
//                    rotation of the card layout, latched on start.
//                    undefined: fixed layout, card i shows animal i mod 6.
// -----------------------------------------------------------------------------
module turn_sequencer
  import chicken_pkg::*;
#(
  parameter int NUM_PLAYERS   = NUM_PLAYERS_DEF,
  parameter int NUM_CARDS     = NUM_CARDS_DEF,
  parameter int REVEAL_CYCLES = 50_000_000,
  parameter int ANIMAL_W      = ANIMAL_W_DEF
) (
  input logic             clk,
  input logic             rst,
  turn_sequencer_if.slave bus
);

  localparam int                 TIMER_W    = $clog2(REVEAL_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REVEAL_CYCLES - 1);
  localparam logic [1:0]         T_LAST     = 2'(NUM_PLAYERS - 1);
  localparam logic [4:0]         CARDS_5    = 5'(NUM_CARDS);

  state_e                state, state_next;
  logic [TIMER_W-1:0]    timer;
  logic [NUM_CARDS-1:0]  used_mask;
  logic [ANIMAL_W-1:0]   card_animal;
  logic [ANIMAL_W-1:0]   pick_animal;
  logic [3:0]            table_idx;
  logic [1:0]            turn;
  logic [4:0]            steps;
  logic [3:0]            shown_idx;

  logic game_start;
  logic pick_ok;
  logic pick_accept;
  logic is_match;
  logic mask_full;

  // ---------------------------------------------------------------------------
  // Pick qualification
  // ---------------------------------------------------------------------------
  logic [15:0] mask_ext;
  assign mask_ext  = 16'(used_mask);
  assign pick_ok   = ({1'b0, bus.pick_idx} < CARDS_5) && !mask_ext[bus.pick_idx];
  assign mask_full = &used_mask;

  assign game_start  = bus.start && ((state == ST_IDLE) || (state == ST_GAME_OVER));
  assign pick_accept = (state == ST_WAIT_PICK) && bus.pick_valid && pick_ok;

`ifdef CARD_SHUFFLE_EN
  // ---------------------------------------------------------------------------
  // Layout rotation: reveal_idx stays physical, only the animal lookup moves.
  // ---------------------------------------------------------------------------
  logic [15:0] lfsr;
  logic [3:0]  offset;
  logic [4:0]  rot_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr   <= LFSR_SEED;
      offset <= '0;
    end else begin
      lfsr <= lfsr_step(lfsr);
      if (game_start) offset <= 4'(lfsr % 16'(NUM_CARDS));
    end
  end

  // Single conditional subtract is enough: both terms are below NUM_CARDS
  // whenever the pick is accepted.
  assign rot_sum   = {1'b0, bus.pick_idx} + {1'b0, offset};
  assign table_idx = (rot_sum >= CARDS_5) ? 4'(rot_sum - CARDS_5) : rot_sum[3:0];
`else
  assign table_idx = bus.pick_idx;
`endif

  card_table #(
    .ANIMAL_W (ANIMAL_W)
  ) u_card_table (
    .card_idx (table_idx),
    .animal   (pick_animal)
  );

  assign is_match = (card_animal == bus.tile_animal);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (bus.start) state_next = ST_WAIT_PICK;
      ST_WAIT_PICK: if (pick_accept) state_next = ST_REVEAL;
      ST_REVEAL:    if (timer == TIMER_LAST) state_next = ST_JUDGE;
      ST_JUDGE:     state_next = is_match ? ST_ADVANCE : ST_NEXT_TURN;
      ST_ADVANCE:   state_next = ST_WAIT_WIN;
      ST_WAIT_WIN: begin
        if (bus.W)          state_next = ST_GAME_OVER;
        else if (mask_full) state_next = ST_NEXT_TURN;
        else                state_next = ST_WAIT_PICK;
      end
      ST_NEXT_TURN: state_next = ST_WAIT_PICK;
      ST_GAME_OVER: if (bus.start) state_next = ST_WAIT_PICK;
      default:      state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Turn datapath: player, step count, used cards, revealed card, reveal timer
  // ---------------------------------------------------------------------------
  // NOTE: the used-card mask is a flag register, not storage, so it is reset
  // along with the rest of the turn state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turn        <= '0;
      steps       <= '0;
      used_mask   <= '0;
      shown_idx   <= '0;
      card_animal <= '0;
      timer       <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_GAME_OVER: begin
          if (game_start) begin
            turn      <= '0;
            steps     <= '0;
            used_mask <= '0;
          end
        end
        ST_WAIT_PICK: begin
          if (pick_accept) begin
            shown_idx   <= bus.pick_idx;
            card_animal <= pick_animal;
            used_mask   <= used_mask | NUM_CARDS'(16'd1 << bus.pick_idx);
            timer       <= '0;
          end
        end
        ST_REVEAL: timer <= timer + TIMER_W'(1);
        ST_JUDGE: begin
          if (is_match && (steps != N_MAX)) steps <= steps + 5'd1;
        end
        ST_NEXT_TURN: begin
          turn      <= (turn == T_LAST) ? 2'd0 : turn + 2'd1;
          steps     <= '0;
          used_mask <= '0;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: strobes decode straight from the registered state
  // ---------------------------------------------------------------------------
  assign bus.T          = turn;
  assign bus.N          = steps;
  assign bus.B          = (state == ST_ADVANCE);
  assign bus.reveal_en  = (state == ST_REVEAL);
  assign bus.reveal_idx = shown_idx;
  assign bus.game_over  = (state == ST_GAME_OVER);

endmodule

// File: tb/tb_turn_sequencer.sv
// -----------------------------------------------------------------------------
// tb_turn_sequencer
// Directed stimulus with a scoreboard: each played card pushes the events it
// must produce (reveal window, advance strobe, turn change, game over); a
// monitor on the falling edge turns DUT activity into events and pops/compares.
// -----------------------------------------------------------------------------
module tb_turn_sequencer;
  import chicken_pkg::*;

  localparam int R = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  turn_sequencer_if #(.ANIMAL_W(3)) bus ();

  turn_sequencer #(
    .NUM_PLAYERS   (4),
    .NUM_CARDS     (12),
    .REVEAL_CYCLES (R),
    .ANIMAL_W      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef enum logic [1:0] {EV_REVEAL, EV_ADV, EV_TURN, EV_GO} ev_kind_e;
  typedef struct packed {
    ev_kind_e kind;
    int       a;   // reveal: idx   adv/turn/go: T
    int       b;   // reveal: len   adv/turn/go: N
    int       c;   // adv: cycles from last reveal cycle to B
  } ev_t;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  // model state
  int          t_m   = 0;
  int          n_m   = 0;
  int          off_m = 0;
  logic [11:0] mask_m = '0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

`ifdef CARD_SHUFFLE_EN
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end
`endif

  function automatic int animal_of(input int idx);
    return ((idx + off_m) % 12) % 6;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic       prev_rev, prev_b, prev_go;
  logic [1:0] prev_t;
  int         rev_len, since_rev;
  int         rev_idx;

  task automatic observe(input ev_t got);
    ev_t exp;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_unexpected: got event %s (a=%0d b=%0d), expected none",
               got.kind.name(), got.a, got.b);
    end else begin
      exp = sb.pop_front();
      check("ev_kind", 32'(got.kind), 32'(exp.kind));
      check($sformatf("%s.a", exp.kind.name()), got.a, exp.a);
      check($sformatf("%s.b", exp.kind.name()), got.b, exp.b);
      check($sformatf("%s.c", exp.kind.name()), got.c, exp.c);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_rev  = 1'b0;
      prev_b    = 1'b0;
      prev_go   = 1'b0;
      prev_t    = 2'd0;
      rev_len   = 0;
      rev_idx   = 0;
      since_rev = 100;
    end else begin
      if (bus.reveal_en) begin
        rev_len++;
        rev_idx = int'(bus.reveal_idx);
      end
      if (prev_rev && !bus.reveal_en) begin
        observe('{EV_REVEAL, rev_idx, rev_len, 0});
        rev_len   = 0;
        since_rev = 1;
      end else if (since_rev < 100) begin
        since_rev++;
      end
      if (bus.B) begin
        check("b_not_consecutive", 32'(prev_b), 32'd0);
        observe('{EV_ADV, int'(bus.T), int'(bus.N), since_rev});
      end
      if (bus.game_over && !prev_go) observe('{EV_GO, int'(bus.T), int'(bus.N), 0});
      if (bus.T != prev_t)           observe('{EV_TURN, int'(bus.T), int'(bus.N), 0});
      prev_rev = bus.reveal_en;
      prev_b   = bus.B;
      prev_go  = bus.game_over;
      prev_t   = bus.T;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic next_turn_m();
    t_m    = (t_m + 1) % 4;
    n_m    = 0;
    mask_m = '0;
    sb.push_back('{EV_TURN, t_m, 0, 0});
  endtask

  task automatic do_start();
    bus.start = 1'b1;
`ifdef CARD_SHUFFLE_EN
    off_m = int'(lfsr_m % 16'd12);
`endif
    if (t_m != 0) sb.push_back('{EV_TURN, 0, 0, 0});
    tick();
    bus.start = 1'b0;
    t_m    = 0;
    n_m    = 0;
    mask_m = '0;
  endtask

  // Plays one valid card; W is driven during the cycle after B.
  task automatic play(input int idx, input int tile, input bit w);
    bus.tile_animal = 3'(tile);
    sb.push_back('{EV_REVEAL, idx, R, 0});
    mask_m[idx] = 1'b1;
    if (animal_of(idx) == tile) begin
      if (n_m < 31) n_m++;
      sb.push_back('{EV_ADV, t_m, n_m, 2});
      if (w)              sb.push_back('{EV_GO, t_m, n_m, 0});
      else if (&mask_m)   next_turn_m();
    end else begin
      next_turn_m();
    end
    bus.pick_valid = 1'b1;
    bus.pick_idx   = 4'(idx);
    tick();
    bus.pick_valid = 1'b0;
    repeat (R + 2) tick();
    bus.W = w;
    tick();
    bus.W = 1'b0;
    tick();
  endtask

  task automatic play_match(input int idx, input bit w);
    play(idx, animal_of(idx), w);
  endtask

  task automatic play_miss(input int idx);
    play(idx, (animal_of(idx) + 1) % 6, 1'b0);
  endtask

  task automatic bad_pick(input int idx, input string name);
    bus.pick_valid = 1'b1;
    bus.pick_idx   = 4'(idx);
    tick();
    bus.pick_valid = 1'b0;
    check(name, 32'(bus.reveal_en), 32'd0);
    repeat (R + 3) tick();
  endtask

  task automatic check_turn(input string name);
    check({name, "_T"}, 32'(bus.T), t_m);
    check({name, "_N"}, 32'(bus.N), n_m);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    bus.start       = 1'b0;
    bus.pick_valid  = 1'b0;
    bus.pick_idx    = '0;
    bus.tile_animal = '0;
    bus.W           = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1. reset values, then reset in the middle of a reveal
    check("rst_T",          32'(bus.T), 32'd0);
    check("rst_N",          32'(bus.N), 32'd0);
    check("rst_B",          32'(bus.B), 32'd0);
    check("rst_reveal_en",  32'(bus.reveal_en), 32'd0);
    check("rst_reveal_idx", 32'(bus.reveal_idx), 32'd0);
    check("rst_game_over",  32'(bus.game_over), 32'd0);
    rst = 1'b0;
    tick();
    do_start();
    bus.pick_valid = 1'b1;
    bus.pick_idx   = 4'd5;
    tick();
    bus.pick_valid = 1'b0;
    tick();
    check("mid_reveal_en",  32'(bus.reveal_en), 32'd1);
    check("mid_reveal_idx", 32'(bus.reveal_idx), 32'd5);
    rst = 1'b1;
    #1;
    check("async_rst_reveal_en",  32'(bus.reveal_en), 32'd0);
    check("async_rst_reveal_idx", 32'(bus.reveal_idx), 32'd0);
    tick();
    rst = 1'b0;
    check("post_rst_T",         32'(bus.T), 32'd0);
    check("post_rst_N",         32'(bus.N), 32'd0);
    check("post_rst_game_over", 32'(bus.game_over), 32'd0);
    tick();
    bad_pick(1, "pick_in_idle_ignored");

    // 2. match on card 2 against tile 2
    do_start();
    play(2, 2, 1'b0);
    check_turn("match_card2");

    // 3. mismatch: card 3 against tile 1 hands the turn to player 1
    play(3, 1, 1'b0);
    check_turn("miss_card3");

    // 4. walk to player 3, ignored picks, then wrap to player 0
    play_miss(0);
    play_miss(1);
    check_turn("reach_T3");
    bad_pick(13, "pick_out_of_range_ignored");
    play_match(4, 1'b0);
    check_turn("T3_match");
    bad_pick(4, "repick_used_ignored");
    play_miss(5);
    check_turn("T_wrap");

    // 5. win ends the game; picks ignored until start
    play_match(6, 1'b1);
    check("win_game_over", 32'(bus.game_over), 32'd1);
    bad_pick(7, "pick_after_win_ignored");
    check("frozen_game_over", 32'(bus.game_over), 32'd1);
    check_turn("frozen");
    do_start();
    tick();
    check("restart_game_over", 32'(bus.game_over), 32'd0);
    check_turn("restart");

    // 6. one player matches every card: N reaches 12, then the turn passes
    for (int i = 0; i < 12; i++) play_match(i, 1'b0);
    check_turn("all_cards");

    repeat (3) tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
